// File: rtl/ddr_ctrl_sched_pkg.sv
// Shared types and default timing for the DDR control scheduler.
// Defaults describe a DDR4-class part at controller clock rate.
package ddr_ctrl_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RW,
        S_DRAIN,
        S_REFRESH,
        S_UPDATE
    } sched_fsm_type;

    localparam int TREF         = 7800;
    localparam int TRFC         = 350;
    localparam int TMOD         = 24;
    localparam int MAX_POSTPONE = 8;
    localparam int MRS_WIDTH    = 13;

endpackage

// File: rtl/ddr_ref_tracker.sv
// Per-rank refresh interval counter with postponement debt.
// Counter starts at a staggered offset on the first RW entry.
module ddr_ref_tracker #(
    parameter int TREF         = ddr_ctrl_sched_pkg::TREF,
    parameter int MAX_POSTPONE = ddr_ctrl_sched_pkg::MAX_POSTPONE,
    parameter int OFFSET       = 0,
    parameter int DW           = $clog2(MAX_POSTPONE + 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dec,
    output logic [DW-1:0] debt,
    output logic          urgent,
    output logic          overflow
);
    import ddr_ctrl_sched_pkg::*;

    localparam int CW = $clog2(TREF + 1);

    logic [CW-1:0] cnt;
    logic          run;
    logic          wrap;

    assign wrap   = run && (cnt == CW'(TREF - 1));
    assign urgent = debt >= DW'(MAX_POSTPONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (start && !run) begin
            cnt <= CW'(OFFSET);
            run <= 1'b1;
        end else if (run) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

    // A wrap and a refresh in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debt     <= '0;
            overflow <= 1'b0;
        end else if (wrap && !dec) begin
            if (debt == DW'(MAX_POSTPONE + 1))
                overflow <= 1'b1;
            else
                debt <= debt + DW'(1);
        end else if (dec && !wrap && debt != '0) begin
            debt <= debt - DW'(1);
        end
    end

endmodule

// File: rtl/ddr_ctrl_sched.sv
// DDR control scheduler: init, read/write, drain, refresh with postponement, MRS.
// Define DDR_SCHED_STATS_EN to add saturating refresh/urgent/MRS counters.
module ddr_ctrl_sched #(
    parameter int NUM_RANKS    = 2,
    parameter int TREF         = ddr_ctrl_sched_pkg::TREF,
    parameter int TRFC         = ddr_ctrl_sched_pkg::TRFC,
    parameter int TMOD         = ddr_ctrl_sched_pkg::TMOD,
    parameter int MAX_POSTPONE = ddr_ctrl_sched_pkg::MAX_POSTPONE,
    parameter int MRS_W        = ddr_ctrl_sched_pkg::MRS_WIDTH
) (
    input  logic                 clock_t,
    input  logic                 reset,
    input  logic                 config_done,
    input  logic                 rw_idle,
    input  logic                 mrs_update,
    input  logic [1:0]           mrs_bl,
    input  logic [MRS_W-1:0]     mr0,
    output logic                 rw_proc,
    output logic                 dev_busy,
    output logic [NUM_RANKS-1:0] refresh_rdy,
    output logic                 mrs_update_rdy,
    output logic [MRS_W-1:0]     mrs_update_cmd,
    output logic                 ref_overflow
`ifdef DDR_SCHED_STATS_EN
    ,
    output logic [31:0]          stat_ref_cnt,
    output logic [31:0]          stat_urgent_cnt,
    output logic [31:0]          stat_mrs_cnt
`endif
);
    import ddr_ctrl_sched_pkg::*;

    localparam int DW = $clog2(MAX_POSTPONE + 2);
    localparam int TW = $clog2((TRFC > TMOD ? TRFC : TMOD) + 1);
    localparam int PW = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;

    sched_fsm_type state, next_state;

    logic [DW-1:0]        debt [NUM_RANKS];
    logic [NUM_RANKS-1:0] urgent;
    logic [NUM_RANKS-1:0] owed;
    logic [NUM_RANKS-1:0] ovf;
    logic [TW-1:0]        timer;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        sel;
    logic [1:0]           bl_lat;
    logic                 mrs_pend;
    logic                 any_urgent;
    logic                 any_owed;
    logic                 ref_go;
    logic                 upd_go;

    for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
        ddr_ref_tracker #(
            .TREF         (TREF),
            .MAX_POSTPONE (MAX_POSTPONE),
            .OFFSET       (r * (TREF / NUM_RANKS)),
            .DW           (DW)
        ) u_trk (
            .clk      (clock_t),
            .rst      (reset),
            .start    (next_state == S_RW),
            .dec      (refresh_rdy[r]),
            .debt     (debt[r]),
            .urgent   (urgent[r]),
            .overflow (ovf[r])
        );
        assign owed[r] = debt[r] != '0;
    end

    assign any_urgent   = |urgent;
    assign any_owed     = |owed;
    assign ref_overflow = |ovf;
    assign rw_proc      = state == S_RW;
    assign dev_busy     = !rw_proc;
    assign ref_go       = (state == S_DRAIN) && (next_state == S_REFRESH);
    assign upd_go       = (state == S_DRAIN) && (next_state == S_UPDATE);

    // Descending scan so the lowest urgent / first owed-from-pointer wins.
    always_comb begin
        sel = '0;
        for (int k = NUM_RANKS - 1; k >= 0; k--) begin
            if (any_urgent) begin
                if (urgent[k])
                    sel = PW'(k);
            end else if (owed[(int'(rr_ptr) + k) % NUM_RANKS]) begin
                sel = PW'((int'(rr_ptr) + k) % NUM_RANKS);
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    next_state = S_INIT;
            S_INIT:    if (config_done) next_state = S_RW;
            S_RW: begin
                if (any_urgent || mrs_pend || (any_owed && rw_idle))
                    next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (rw_idle) begin
                    if (any_urgent)    next_state = S_REFRESH;
                    else if (mrs_pend) next_state = S_UPDATE;
                    else if (any_owed) next_state = S_REFRESH;
                    else               next_state = S_RW;
                end
            end
            S_REFRESH: if (timer == TW'(TRFC - 1)) next_state = S_RW;
            S_UPDATE:  if (timer == TW'(TMOD - 1)) next_state = S_RW;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            timer          <= '0;
            rr_ptr         <= '0;
            refresh_rdy    <= '0;
            mrs_update_rdy <= 1'b0;
            mrs_update_cmd <= '0;
            mrs_pend       <= 1'b0;
            bl_lat         <= 2'b00;
        end else begin
            state          <= next_state;
            timer          <= (next_state != state) ? '0 : timer + TW'(1);
            refresh_rdy    <= ref_go ? (NUM_RANKS'(1) << sel) : '0;
            mrs_update_rdy <= upd_go;
            if (ref_go)
                rr_ptr <= (sel == PW'(NUM_RANKS - 1)) ? '0 : sel + PW'(1);
            if (upd_go)
                mrs_update_cmd <= {mr0[MRS_W-1:2], bl_lat};
            // A request landing on the entry cycle survives the clear.
            if (mrs_update) begin
                mrs_pend <= 1'b1;
                bl_lat   <= mrs_bl;
            end else if (upd_go) begin
                mrs_pend <= 1'b0;
            end
        end
    end

`ifdef DDR_SCHED_STATS_EN
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            stat_ref_cnt    <= '0;
            stat_urgent_cnt <= '0;
            stat_mrs_cnt    <= '0;
        end else begin
            if ((|refresh_rdy) && stat_ref_cnt != '1)
                stat_ref_cnt <= stat_ref_cnt + 32'd1;
            if (ref_go && any_urgent && stat_urgent_cnt != '1)
                stat_urgent_cnt <= stat_urgent_cnt + 32'd1;
            if (mrs_update_rdy && stat_mrs_cnt != '1)
                stat_mrs_cnt <= stat_mrs_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_ctrl_sched.sv
// Randomized bench for ddr_ctrl_sched against a behavioural scheduler model.
// Directed phases pin stagger order, MRS command, overflow and async reset.
module tb_ddr_ctrl_sched;

    localparam int NR   = 4;
    localparam int TREF = 40;
    localparam int TRFC = 5;
    localparam int TMOD = 6;
    localparam int MAXP = 3;
    localparam int MW   = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          config_done;
    logic          rw_idle;
    logic          mrs_update;
    logic [1:0]    mrs_bl;
    logic [MW-1:0] mr0;
    logic          rw_proc;
    logic          dev_busy;
    logic [NR-1:0] refresh_rdy;
    logic          mrs_update_rdy;
    logic [MW-1:0] mrs_update_cmd;
    logic          ref_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ddr_ctrl_sched #(
        .NUM_RANKS    (NR),
        .TREF         (TREF),
        .TRFC         (TRFC),
        .TMOD         (TMOD),
        .MAX_POSTPONE (MAXP),
        .MRS_W        (MW)
    ) dut (
        .clock_t        (clk),
        .reset          (reset),
        .config_done    (config_done),
        .rw_idle        (rw_idle),
        .mrs_update     (mrs_update),
        .mrs_bl         (mrs_bl),
        .mr0            (mr0),
        .rw_proc        (rw_proc),
        .dev_busy       (dev_busy),
        .refresh_rdy    (refresh_rdy),
        .mrs_update_rdy (mrs_update_rdy),
        .mrs_update_cmd (mrs_update_cmd),
        .ref_overflow   (ref_overflow)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: scheduler modes, per-rank debt, arithmetic intervals.
    typedef enum {M_IDLE, M_INIT, M_RW, M_DRAIN, M_REF, M_UPD} mode_t;
    mode_t         mode;
    int            debt [NR];
    int            left, elapsed, ptr;
    bit            started, pend, ovf;
    logic [1:0]    bl;
    logic [NR-1:0] e_ref;
    logic          e_mrs;
    logic [MW-1:0] e_cmd;

    task automatic model_step();
        bit            urg, owed, w, d;
        int            pick;
        mode_t         nxt;
        logic [NR-1:0] ref_now;
        urg = 0;
        owed = 0;
        for (int r = 0; r < NR; r++) begin
            if (debt[r] >= MAXP) urg = 1;
            if (debt[r] > 0) owed = 1;
        end
        nxt = mode;
        case (mode)
            M_IDLE:  nxt = M_INIT;
            M_INIT:  if (config_done) nxt = M_RW;
            M_RW:    if (urg || pend || (owed && rw_idle)) nxt = M_DRAIN;
            M_DRAIN: if (rw_idle) nxt = urg ? M_REF : pend ? M_UPD : owed ? M_REF : M_RW;
            M_REF:   if (left == 1) nxt = M_RW;
            M_UPD:   if (left == 1) nxt = M_RW;
            default: nxt = M_IDLE;
        endcase
        if (mode == M_REF || mode == M_UPD) left--;
        ref_now = e_ref;
        e_ref = '0;
        e_mrs = 1'b0;
        if (mode == M_DRAIN && nxt == M_REF) begin
            pick = -1;
            for (int r = 0; r < NR; r++)
                if (pick < 0 && debt[r] >= MAXP) pick = r;
            if (pick < 0)
                for (int k = 0; k < NR; k++)
                    if (pick < 0 && debt[(ptr + k) % NR] > 0) pick = (ptr + k) % NR;
            e_ref[pick] = 1'b1;
            ptr = (pick + 1) % NR;
            left = TRFC;
        end
        if (mode == M_DRAIN && nxt == M_UPD) begin
            e_mrs = 1'b1;
            e_cmd = {mr0[MW-1:2], bl};
            left = TMOD;
        end
        if (started) begin
            for (int r = 0; r < NR; r++) begin
                w = ((r * (TREF / NR) + elapsed) % TREF) == TREF - 1;
                d = ref_now[r];
                if (w && !d) begin
                    if (debt[r] == MAXP + 1) ovf = 1;
                    else debt[r]++;
                end else if (d && !w && debt[r] > 0) begin
                    debt[r]--;
                end
            end
            elapsed++;
        end else if (nxt == M_RW) begin
            started = 1;
            elapsed = 0;
        end
        if (mrs_update) begin
            pend = 1;
            bl = mrs_bl;
        end else if (e_mrs) begin
            pend = 0;
        end
        mode = nxt;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mode = M_IDLE;
            started = 0; elapsed = 0; ptr = 0; left = 0;
            pend = 0; ovf = 0; bl = 2'b00;
            e_ref = '0; e_mrs = 1'b0; e_cmd = '0;
            for (int r = 0; r < NR; r++) debt[r] = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        chk("rw_proc", 32'(rw_proc), 32'(mode == M_RW));
        chk("dev_busy", 32'(dev_busy), 32'(mode != M_RW));
        chk("refresh_rdy", 32'(refresh_rdy), 32'(e_ref));
        chk("mrs_update_rdy", 32'(mrs_update_rdy), 32'(e_mrs));
        chk("mrs_update_cmd", 32'(mrs_update_cmd), 32'(e_cmd));
        chk("ref_overflow", 32'(ref_overflow), 32'(ovf));
    end

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rw_idle    = $urandom_range(0, 3) != 0;
            mrs_update = $urandom_range(0, 39) == 0;
            mrs_bl     = 2'($urandom);
            if ($urandom_range(0, 15) == 0) mr0 = MW'($urandom);
        end
        mrs_update = 1'b0;
    endtask

    int ref_at [4];
    int ref_mask [4];
    int nref, cyc, first_ref, first_upd;

    initial begin
        reset = 1'b1; config_done = 1'b0; rw_idle = 1'b1;
        mrs_update = 1'b0; mrs_bl = 2'b00; mr0 = '0;
        repeat (3) @(negedge clk);
        chk("reset_rw_proc", 32'(rw_proc), 32'd0);
        chk("reset_dev_busy", 32'(dev_busy), 32'd1);
        chk("reset_cmd", 32'(mrs_update_cmd), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("init_hold", 32'(rw_proc), 32'd0);

        // Staggered first refreshes: ranks wrap 10 cycles apart, newest offset first.
        config_done = 1'b1;
        cyc = 0;
        while (!rw_proc && cyc < 20) begin @(negedge clk); cyc++; end
        chk("rw_entry", 32'(rw_proc), 32'd1);
        nref = 0;
        for (int i = 0; i < 4; i++) begin ref_at[i] = -1; ref_mask[i] = 0; end
        for (int e = 1; e <= 45; e++) begin
            @(negedge clk);
            if (refresh_rdy != '0 && nref < 4) begin
                ref_at[nref] = e;
                ref_mask[nref] = int'(refresh_rdy);
                nref++;
            end
        end
        chk("stagger_t0", 32'(ref_at[0]), 32'd12);
        chk("stagger_m0", 32'(ref_mask[0]), 32'h8);
        chk("stagger_t1", 32'(ref_at[1]), 32'd22);
        chk("stagger_m1", 32'(ref_mask[1]), 32'h4);
        chk("stagger_t2", 32'(ref_at[2]), 32'd32);
        chk("stagger_m2", 32'(ref_mask[2]), 32'h2);
        chk("stagger_t3", 32'(ref_at[3]), 32'd42);
        chk("stagger_m3", 32'(ref_mask[3]), 32'h1);

        // MRS burst-length update.
        cyc = 0;
        while (!rw_proc && cyc < 20) begin @(negedge clk); cyc++; end
        mr0 = 13'h0A31; mrs_bl = 2'b10; mrs_update = 1'b1;
        @(negedge clk);
        mrs_update = 1'b0;
        cyc = 0;
        while (!mrs_update_rdy && cyc < 50) begin @(negedge clk); cyc++; end
        chk("mrs_pulse", 32'(mrs_update_rdy), 32'd1);
        chk("mrs_cmd", 32'(mrs_update_cmd), 32'h0A32);
        cyc = 0;
        while (!rw_proc && cyc < 50) begin @(negedge clk); cyc++; end
        chk("update_len", 32'(cyc), 32'(TMOD));

        // Postpone until urgent and overflow, with an MRS request queued.
        rw_idle = 1'b0;
        repeat (20) @(negedge clk);
        mr0 = 13'h1FFC; mrs_bl = 2'b01; mrs_update = 1'b1;
        @(negedge clk);
        mrs_update = 1'b0;
        repeat (300) @(negedge clk);
        chk("overflow_set", 32'(ref_overflow), 32'd1);
        chk("drain_holds", 32'(rw_proc), 32'd0);
        rw_idle = 1'b1;
        first_ref = -1; first_upd = -1;
        for (int i = 0; i < 600 && first_upd < 0; i++) begin
            @(negedge clk);
            if (refresh_rdy != '0 && first_ref < 0) first_ref = i;
            if (mrs_update_rdy && first_upd < 0) first_upd = i;
        end
        chk("urgent_ref_seen", 32'(first_ref >= 0), 32'd1);
        chk("upd_seen", 32'(first_upd >= 0), 32'd1);
        chk("ref_before_upd", 32'(first_ref < first_upd), 32'd1);
        chk("mrs_cmd2", 32'(mrs_update_cmd), 32'h1FFD);
        chk("overflow_sticky", 32'(ref_overflow), 32'd1);

        rand_run(3000);

        // Asynchronous reset in the middle of a refresh.
        rw_idle = 1'b1;
        cyc = 0;
        while (refresh_rdy == '0 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("mid_ref_found", 32'(refresh_rdy != '0), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rw_proc", 32'(rw_proc), 32'd0);
        chk("async_dev_busy", 32'(dev_busy), 32'd1);
        chk("async_refresh_rdy", 32'(refresh_rdy), 32'd0);
        chk("async_mrs_rdy", 32'(mrs_update_rdy), 32'd0);
        chk("async_cmd", 32'(mrs_update_cmd), 32'd0);
        chk("async_overflow", 32'(ref_overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0; config_done = 1'b0;
        repeat (4) @(negedge clk);
        config_done = 1'b1;
        rand_run(1500);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
